div: RTL

- Multi-cycle 32-bit integer divider for DIV/DIVU, instantiated inside the EX stage.
- EX holds `start_i` high and asserts its stall request toward the pipeline stall controller (`stall_from_ex`) while `ready_o` is low, which freezes IF/ID/EX.
- Produces `{remainder, quotient}` for the HI/LO write-back path.
- Uses radix-2 restoring trial subtraction, one quotient bit per cycle.

---
 rtl/div.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/div.sv
// div -- multi-cycle 32-bit integer divider for DIV/DIVU in the EX stage.
//
// Radix-2 restoring division, one quotient bit per cycle. A division
// started from DivFree completes 33 cycles after the start edge. A zero
// divisor completes one cycle after the start edge with a zero result.
// The result is held while start_i stays high. Dropping start_i in DivEnd
// releases the result and returns the divider to DivFree.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   : signed_div_i selects a signed division (DIV). Operands are
//               converted to magnitudes and the results are sign-corrected.
//   undefined : every division is unsigned and signed_div_i is ignored.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   signed_div_i in   1 = DIV (signed), 0 = DIVU
//   opdata1_i    in   [31:0] dividend, sampled only at the start edge
//   opdata2_i    in   [31:0] divisor, sampled only at the start edge
//   start_i      in   division request, held until the result is consumed
//   annul_i      in   cancels a division while it is iterating
//   result_o     out  [63:0] {remainder, quotient} (HI, LO), registered
//   ready_o      out  result valid, registered

module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      DivFree,
      DivByZero,
      DivOn,
      DivEnd
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [64:0] work_q, work_d;
   logic [31:0] divisor_q, divisor_d;
   logic        ready_q, ready_d;
   logic [63:0] result_q, result_d;

   logic [32:0] diff;
   logic [31:0] dividend_abs;
   logic [31:0] divisor_abs;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        start_ok;

   assign start_ok = (state_q == DivFree) && start_i && !annul_i;

`ifdef DIV_SIGNED_EN
   // Sign corrections are decided from the operands at the start edge and
   // kept, because the operand inputs may change during the iteration.
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   assign dividend_abs = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
   assign divisor_abs  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

   always_comb begin
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (start_ok) begin
         neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
         neg_rem_d = signed_div_i && opdata1_i[31];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign quo = neg_quo_q ? -work_q[31:0]  : work_q[31:0];
   assign rem = neg_rem_q ? -work_q[64:33] : work_q[64:33];
`else
   logic unused_signed_div;
   assign unused_signed_div = signed_div_i;

   assign dividend_abs = opdata1_i;
   assign divisor_abs  = opdata2_i;
   assign quo          = work_q[31:0];
   assign rem          = work_q[64:33];
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      ready_d   = ready_q;
      result_d  = result_q;

      // Trial subtraction of the divisor from the partial remainder; bit 32
      // set means the subtraction borrowed and the quotient bit is 0.
      diff = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

      case (state_q)
         DivFree: begin
            ready_d  = 1'b0;
            result_d = '0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = DivByZero;
               end else begin
                  divisor_d = divisor_abs;
                  work_d    = {32'b0, dividend_abs, 1'b0};
                  cnt_d     = '0;
                  state_d   = DivOn;
               end
            end
         end

         DivByZero: begin
            work_d   = '0;
            ready_d  = 1'b1;
            result_d = '0;
            state_d  = DivEnd;
         end

         DivOn: begin
            if (annul_i) begin
               ready_d  = 1'b0;
               result_d = '0;
               state_d  = DivFree;
            end else if (cnt_q != 6'd32) begin
               if (diff[32]) begin
                  work_d = {work_q[63:0], 1'b0};
               end else begin
                  work_d = {diff[31:0], work_q[31:0], 1'b1};
               end
               cnt_d = cnt_q + 6'd1;
            end else begin
               result_d = {rem, quo};
               ready_d  = 1'b1;
               state_d  = DivEnd;
            end
         end

         DivEnd: begin
            if (!start_i) begin
               ready_d  = 1'b0;
               result_d = '0;
               state_d  = DivFree;
            end
         end

         default: begin
            state_d = DivFree;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         ready_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
      end
   end

   assign ready_o  = ready_q;
   assign result_o = result_q;

endmodule
